// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready handshake and sequence accumulate.
// Optional full IEEE specials/subnormal handling: define FP_ADD_PIPE_IEEE_SPECIALS_EN.
module fp_add_pipe #(
    parameter int unsigned EXPONENT = 5,
    parameter int unsigned MANTISSA = 10,
    localparam int unsigned DWIDTH = 1 + EXPONENT + MANTISSA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              op,
    input  logic              acc_mode,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic [3:0]        flags
);

    localparam int unsigned SW    = MANTISSA + 1;
    localparam int unsigned AW    = MANTISSA + 4;
    localparam int unsigned SUMW  = MANTISSA + 5;
    localparam int unsigned SHW   = $clog2(SUMW + 1);
    localparam int unsigned XW    = ((EXPONENT > SHW) ? EXPONENT : SHW) + 2;
    localparam int unsigned SHMAX = MANTISSA + 3;
    localparam int unsigned EMAX  = (2 ** EXPONENT) - 1;

    localparam logic signed [XW-1:0] XONE  = XW'(1);
    localparam logic signed [XW-1:0] XEMAX = XW'(EMAX);
`ifdef FP_ADD_PIPE_IEEE_SPECIALS_EN
    localparam logic [DWIDTH-1:0] QNAN = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
    localparam logic [DWIDTH-2:0] INF  = {{EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
`else
    localparam logic [EXPONENT-1:0] EMAXF = {{(EXPONENT-1){1'b1}}, 1'b0};
`endif

    typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

    state_t state_q, state_d;

    logic              stall, en, accept_c;
    logic [DWIDTH-1:0] acc_q;
    logic [3:0]        acc_flags_q;

    // Stage registers
    logic                s1_v, s1_acc, s1_last, s1_sx, s1_sub, s1_spec, s1_inv;
    logic [EXPONENT-1:0] s1_ex, s1_diff;
    logic [SW-1:0]       s1_mx, s1_my;
    logic [DWIDTH-1:0]   s1_sres;
    logic                s2_v, s2_acc, s2_last, s2_sx, s2_sub, s2_spec, s2_inv;
    logic [EXPONENT-1:0] s2_ex;
    logic [SUMW-1:0]     s2_sum;
    logic [DWIDTH-1:0]   s2_sres;

    // Returns {exponent, significand with hidden bit}; zero-exponent handling depends on the build
    function automatic logic [EXPONENT+MANTISSA:0] unpack(input logic [DWIDTH-2:0] v);
        logic [EXPONENT-1:0] fe;
        fe = v[DWIDTH-2 -: EXPONENT];
`ifdef FP_ADD_PIPE_IEEE_SPECIALS_EN
        unpack = {((fe == '0) ? EXPONENT'(1) : fe), (fe != '0), v[MANTISSA-1:0]};
`else
        unpack = (fe == '0) ? '0 : {fe, 1'b1, v[MANTISSA-1:0]};
`endif
    endfunction

    function automatic logic [SHW-1:0] lzc(input logic [SUMW-1:0] v);
        lzc = SHW'(SUMW);
        for (int i = 0; i < SUMW; i++) begin
            if (v[i]) lzc = SHW'(SUMW - 1 - i);
        end
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign accept_c = in_valid & in_ready;

    // Accumulate FSM: one accumulate beat in flight at a time
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = reset & en;
                if (in_valid && in_ready && acc_mode) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (en && s2_v && s2_acc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // S1: operand select, unpack, magnitude swap, exponent difference
    logic [DWIDTH-1:0]        opa, opb;
    logic                     sa, sb, a_ge;
    logic [EXPONENT+MANTISSA:0] ua, ub;
    logic                     c1_sx, c1_spec, c1_inv;
    logic [EXPONENT-1:0]      c1_ex, c1_ey;
    logic [SW-1:0]            c1_mx, c1_my;
    logic [DWIDTH-1:0]        c1_sres;
`ifdef FP_ADD_PIPE_IEEE_SPECIALS_EN
    logic                     ones_a, ones_b, nan_a, nan_b, inf_a, inf_b;
`endif

    always_comb begin
        opa  = acc_mode ? acc_q : a;
        opb  = acc_mode ? a : b;
        sa   = opa[DWIDTH-1];
        sb   = opb[DWIDTH-1] ^ op;
        ua   = unpack(opa[DWIDTH-2:0]);
        ub   = unpack(opb[DWIDTH-2:0]);
        a_ge = (ua >= ub);
        c1_sx = a_ge ? sa : sb;
        c1_ex = a_ge ? ua[EXPONENT+MANTISSA -: EXPONENT] : ub[EXPONENT+MANTISSA -: EXPONENT];
        c1_ey = a_ge ? ub[EXPONENT+MANTISSA -: EXPONENT] : ua[EXPONENT+MANTISSA -: EXPONENT];
        c1_mx = a_ge ? ua[SW-1:0] : ub[SW-1:0];
        c1_my = a_ge ? ub[SW-1:0] : ua[SW-1:0];
        c1_spec = 1'b0;
        c1_inv  = 1'b0;
        c1_sres = '0;
`ifdef FP_ADD_PIPE_IEEE_SPECIALS_EN
        ones_a = &opa[DWIDTH-2 -: EXPONENT];
        ones_b = &opb[DWIDTH-2 -: EXPONENT];
        nan_a  = ones_a & (|opa[MANTISSA-1:0]);
        nan_b  = ones_b & (|opb[MANTISSA-1:0]);
        inf_a  = ones_a & ~(|opa[MANTISSA-1:0]);
        inf_b  = ones_b & ~(|opb[MANTISSA-1:0]);
        c1_spec = nan_a | nan_b | inf_a | inf_b;
        c1_inv  = inf_a & inf_b & (sa ^ sb);
        if (nan_a || nan_b || c1_inv) c1_sres = QNAN;
        else if (inf_a)               c1_sres = {sa, INF};
        else                          c1_sres = {sb, INF};
`endif
    end

    // S2: align smaller operand with guard/round/sticky, then add or subtract
    logic [31:0]     diff_ext;
    logic [SHW-1:0]  sh;
    logic [AW-1:0]   ext_y, mask, aligned;
    logic [SUMW-1:0] x_ext, y_ext, c2_sum;

    always_comb begin
        diff_ext = 32'(s1_diff);
        sh       = (diff_ext > SHMAX) ? SHW'(SHMAX) : SHW'(diff_ext);
        ext_y    = {s1_my, 3'b000};
        mask     = ~({AW{1'b1}} << sh);
        aligned  = (ext_y >> sh) | AW'(|(ext_y & mask));
        x_ext    = {1'b0, s1_mx, 3'b000};
        y_ext    = {1'b0, aligned};
        c2_sum   = s1_sub ? (x_ext - y_ext) : (x_ext + y_ext);
    end

    // S3: normalise, round to nearest even, pack, flags
    logic [SHW-1:0]         lz;
    logic signed [XW-1:0]   e_x, shl, e_n, e_r;
    logic [AW-1:0]          n;
    logic                   tiny, g, rs, rup, lead, inexact, ovf;
    logic [MANTISSA+1:0]    rnd;
    logic [MANTISSA-1:0]    frac;
    logic [EXPONENT-1:0]    exp_f;
    logic [DWIDTH-1:0]      res_c;
    logic [3:0]             flg_c;

    always_comb begin
        lz  = lzc(s2_sum);
        e_x = $signed(XW'(s2_ex));
        shl = '0;
        n   = '0;
        e_n = e_x;
        if (lz == '0) begin
            n   = {s2_sum[SUMW-1:2], |s2_sum[1:0]};
            e_n = e_x + XONE;
        end else begin
            shl = $signed(XW'(lz)) - XONE;
`ifdef FP_ADD_PIPE_IEEE_SPECIALS_EN
            // exponent floor of 1 leaves a subnormal significand
            if (shl > (e_x - XONE)) shl = e_x - XONE;
`endif
            n   = AW'(s2_sum << SHW'(shl));
            e_n = e_x - shl;
        end
`ifdef FP_ADD_PIPE_IEEE_SPECIALS_EN
        tiny = ~n[AW-1];
`else
        tiny = (e_n < XONE);
`endif
        g   = n[2];
        rs  = |n[1:0];
        rup = g & (rs | n[3]);
        rnd = {1'b0, n[AW-1:3]} + (MANTISSA+2)'(rup);
        if (rnd[MANTISSA+1]) begin
            frac = rnd[MANTISSA:1];
            e_r  = e_n + XONE;
            lead = 1'b1;
        end else begin
            frac = rnd[MANTISSA-1:0];
            e_r  = e_n;
            lead = rnd[MANTISSA];
        end
        inexact = g | rs;
        ovf     = (e_r >= XEMAX);
        exp_f   = lead ? EXPONENT'(e_r) : '0;
        res_c   = '0;
        flg_c   = '0;
        if (s2_spec) begin
            res_c = s2_sres;
            flg_c = {s2_inv, 3'b000};
        end else if (s2_sum == '0) begin
            res_c = {~s2_sub & s2_sx, {(DWIDTH-1){1'b0}}};
        end else if (ovf) begin
`ifdef FP_ADD_PIPE_IEEE_SPECIALS_EN
            res_c = {s2_sx, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
`else
            res_c = {s2_sx, EMAXF, {MANTISSA{1'b1}}};
`endif
            flg_c = 4'b0101;
        end
`ifndef FP_ADD_PIPE_IEEE_SPECIALS_EN
        else if (tiny) begin
            res_c = {s2_sx, {(DWIDTH-1){1'b0}}};
            flg_c = 4'b0011;
        end
`endif
        else begin
            res_c = {s2_sx, exp_f, frac};
            flg_c = {2'b00, tiny & inexact, inexact};
        end
    end

    // Pipeline, accumulator and output registers; everything freezes while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            acc_flags_q <= '0;
            s1_v <= 1'b0; s1_acc <= 1'b0; s1_last <= 1'b0; s1_sx <= 1'b0;
            s1_sub <= 1'b0; s1_spec <= 1'b0; s1_inv <= 1'b0;
            s1_ex <= '0; s1_diff <= '0; s1_mx <= '0; s1_my <= '0; s1_sres <= '0;
            s2_v <= 1'b0; s2_acc <= 1'b0; s2_last <= 1'b0; s2_sx <= 1'b0;
            s2_sub <= 1'b0; s2_spec <= 1'b0; s2_inv <= 1'b0;
            s2_ex <= '0; s2_sum <= '0; s2_sres <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            state_q <= state_d;
            if (en) begin
                s1_v    <= accept_c;
                s1_acc  <= acc_mode;
                s1_last <= in_last;
                s1_sx   <= c1_sx;
                s1_sub  <= sa ^ sb;
                s1_spec <= c1_spec;
                s1_inv  <= c1_inv;
                s1_ex   <= c1_ex;
                s1_diff <= c1_ex - c1_ey;
                s1_mx   <= c1_mx;
                s1_my   <= c1_my;
                s1_sres <= c1_sres;

                s2_v    <= s1_v;
                s2_acc  <= s1_acc;
                s2_last <= s1_last;
                s2_sx   <= s1_sx;
                s2_sub  <= s1_sub;
                s2_spec <= s1_spec;
                s2_inv  <= s1_inv;
                s2_ex   <= s1_ex;
                s2_sum  <= c2_sum;
                s2_sres <= s1_sres;

                out_valid <= s2_v & (~s2_acc | s2_last);
                if (s2_v && (!s2_acc || s2_last)) begin
                    result <= res_c;
                    flags  <= s2_acc ? (flg_c | acc_flags_q) : flg_c;
                end
                if (s2_v && s2_acc) begin
                    if (s2_last) begin
                        acc_q       <= '0;
                        acc_flags_q <= '0;
                    end else begin
                        acc_q       <= res_c;
                        acc_flags_q <= acc_flags_q | flg_c;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed testbench for fp_add_pipe (FP16): latency, rounding, overflow, accumulate, stall, reset.
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, op, acc_mode, in_last, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic [3:0]  flags;

    int nvec = 0;
    int nerr = 0;

    logic [15:0] ba [4];
    logic [15:0] bb [4];
    logic        bop[4];
    logic [15:0] br [4];
    logic [3:0]  bf [4];

    fp_add_pipe #(.EXPONENT(5), .MANTISSA(10)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vop,
                         input logic vacc, input logic vlast);
        in_valid = 1'b1; a = va; b = vb; op = vop; acc_mode = vacc; in_last = vlast;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; acc_mode = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic single(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vop, input logic [15:0] er, input logic [3:0] ef);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        drive(va, vb, vop, 1'b0, 1'b0);
        @(negedge clk); idle_in();
        @(negedge clk); chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_flg"}, 32'(flags), 32'(ef));
    endtask

    task automatic acc_beat(input string tag, input logic [15:0] va, input logic last);
        wait_ready(tag);
        chk({tag, "_quiet"}, 32'(out_valid), 32'd0);
        drive(va, 16'h0000, 1'b0, 1'b1, last);
        @(negedge clk); idle_in();
        chk({tag, "_wait"}, 32'(in_ready), 32'd0);
        chk({tag, "_novld"}, 32'(out_valid), 32'd0);
    endtask

    task automatic wait_out(input string tag, input logic [15:0] er, input logic [3:0] ef);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_flg"}, 32'(flags), 32'(ef));
        @(negedge clk);
        chk({tag, "_once"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
        in_valid = 1'b0; acc_mode = 1'b0; in_last = 1'b0;
        ba  = '{16'h3C00, 16'h4000, 16'h3C00, 16'h6800};
        bb  = '{16'h4000, 16'h3C00, 16'h3C00, 16'h3C00};
        bop = '{1'b0, 1'b1, 1'b1, 1'b0};
        br  = '{16'h4200, 16'h3C00, 16'h0000, 16'h6800};
        bf  = '{4'h0, 4'h0, 4'h0, 4'h1};

        @(negedge clk); @(negedge clk);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_flg", 32'(flags), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        single("add_1_2",  16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'h0);
        single("sub_zero", 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'h0);
        single("tie_even", 16'h6800, 16'h3C00, 1'b0, 16'h6800, 4'h1);
`ifdef FP_ADD_PIPE_IEEE_SPECIALS_EN
        single("ovf",      16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5);
        single("tiny",     16'h0401, 16'h0400, 1'b1, 16'h0001, 4'h0);
`else
        single("ovf",      16'h7BFF, 16'h7BFF, 1'b0, 16'h7BFF, 4'h5);
        single("tiny",     16'h0401, 16'h0400, 1'b1, 16'h0000, 4'h3);
`endif
        single("sub_neg",  16'h3C00, 16'h4000, 1'b1, 16'hBC00, 4'h0);
        single("neg_add",  16'hBC00, 16'hBC00, 1'b0, 16'hC000, 4'h0);
        single("negzero",  16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0);
        single("cancel",   16'h3C01, 16'h3C00, 1'b1, 16'h1400, 4'h0);
        single("rnd_up",   16'h3C00, 16'h1600, 1'b0, 16'h3C02, 4'h1);

        // back-to-back beats, one result per cycle
        for (int i = 0; i < 7; i++) begin
            if (i >= 3) begin
                chk($sformatf("b2b%0d_vld", i - 3), 32'(out_valid), 32'd1);
                chk($sformatf("b2b%0d_res", i - 3), 32'(result), 32'(br[i-3]));
                chk($sformatf("b2b%0d_flg", i - 3), 32'(flags), 32'(bf[i-3]));
            end
            if (i < 4) begin
                chk($sformatf("b2b%0d_rdy", i), 32'(in_ready), 32'd1);
                drive(ba[i], bb[i], bop[i], 1'b0, 1'b0);
            end else begin
                idle_in();
            end
            @(negedge clk);
        end
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // accumulate 1 + 2 + 3 + 0.5 = 6.5
        acc_beat("acc0", 16'h3C00, 1'b0);
        acc_beat("acc1", 16'h4000, 1'b0);
        acc_beat("acc2", 16'h4200, 1'b0);
        acc_beat("acc3", 16'h3800, 1'b1);
        wait_out("acc_sum", 16'h4680, 4'h0);

        // backpressure with three beats in flight
        wait_ready("stall_pre");
        out_ready = 1'b0;
        drive(16'h6800, 16'h3C00, 1'b0, 1'b0, 1'b0); @(negedge clk);
        drive(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0); @(negedge clk);
        drive(16'h4200, 16'h3C00, 1'b1, 1'b0, 1'b0); @(negedge clk);
        idle_in();
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("stall%0d_vld", j), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_res", j), 32'(result), 32'h6800);
            chk($sformatf("stall%0d_flg", j), 32'(flags), 32'h1);
            chk($sformatf("stall%0d_rdy", j), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel1_vld", 32'(out_valid), 32'd1);
        chk("rel1_res", 32'(result), 32'h4400);
        chk("rel1_flg", 32'(flags), 32'h0);
        @(negedge clk);
        chk("rel2_vld", 32'(out_valid), 32'd1);
        chk("rel2_res", 32'(result), 32'h4000);
        @(negedge clk);
        chk("rel_drain", 32'(out_valid), 32'd0);

        // reset with beats in flight and a partial accumulation
        acc_beat("pre_acc", 16'h4000, 1'b0);
        wait_ready("mid_b0");
        drive(16'h3C00, 16'h4000, 1'b0, 1'b0, 1'b0); @(negedge clk);
        chk("mid_b1_rdy", 32'(in_ready), 32'd1);
        drive(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0); @(negedge clk);
        idle_in();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_vld", 32'(out_valid), 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("mrst_stale%0d", j), 32'(out_valid), 32'd0);
        end
        acc_beat("post_acc", 16'h3C00, 1'b1);
        wait_out("post_sum", 16'h3C00, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-style floating-point adder/subtractor with valid/ready handshake and a sequence-accumulate mode.
- Next generation of the single-op FP16 adder wrapper used in the DSP-slice designs.
- Generic exponent and mantissa widths (FP16 default, BF16/FP32 by parameter).
- Fixed 3-cycle pipeline. Output backpressure stalls the whole pipe.

Parameters:
EXPONENT, 5, exponent field width (>=4)
MANTISSA, 10, stored fraction width (>=4)
DWIDTH, 1+EXPONENT+MANTISSA, operand/result width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
a  in  DWIDTH  operand A
b  in  DWIDTH  operand B (ignored in accumulate mode)
op  in  1  0 = a+b, 1 = a-b (accumulate: 0 = acc+a, 1 = acc-a)
acc_mode  in  1  sampled with beat; 1 = accumulate sequence
in_last  in  1  last beat of accumulate sequence
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  DWIDTH  sum/difference
flags  out  4  {invalid, overflow, underflow, inexact} for result

Behaviour:
- Reset (reset==0 at clk edge): out_valid=0, result=0, flags=0, in_ready=0 during reset then 1, accumulator=+0, FSM=IDLE, all stage valids cleared. Reset mid-operation discards in-flight beats with no output.
- Beat accepted when in_valid && in_ready.
- Pipeline:
  - S1: unpack, swap so |X|>=|Y|, exponent diff.
  - S2: align with guard/round/sticky (shift saturates at MANTISSA+3), add/sub.
  - S3: normalise (leading-zero count), round-to-nearest-even, pack, flags.
- Latency: result of a beat accepted at cycle N is on result/out_valid at N+3 when unstalled.
- Stall: out_valid && !out_ready freezes all stages. in_ready = !(stall) && FSM permits. result/flags hold stable while stalled.
- Non-accumulate beats are fully pipelined: 1 beat/cycle throughput.
- Exact-zero difference yields +0. (-0)+(-0) yields -0.
- Accumulate FSM:
  - IDLE: beat with acc_mode=1 issues acc(+0 initially) op a, goes to WAIT.
  - WAIT: in_ready=0 until that beat exits S3. Result is written to the accumulator, not emitted (out_valid stays 0) unless the beat had in_last=1. Then go to IDLE; on in_last, emit the result and reset the accumulator to +0.
  - A non-accumulate beat in IDLE uses the pipe normally. Switching modes needs no drain.
- Flags:
  - inexact on any discarded nonzero bits.
  - overflow when the rounded exponent reaches all-ones.
  - underflow when the result is tiny and inexact.
  - invalid per the Optional Feature.
- In accumulate mode, flags are OR-accumulated over the sequence and emitted with the in_last result.

Optional Feature:
- Macro: FP_ADD_PIPE_IEEE_SPECIALS_EN.
- Defined:
  - Full IEEE handling: NaN in -> quiet NaN out (all-ones exponent, fraction MSB set), invalid=1 for inf-inf.
  - Inf propagates. Overflow -> signed Inf.
  - Subnormal inputs and outputs supported.
- Undefined:
  - Subnormal inputs treated as zero; subnormal results flushed to signed zero with underflow=1.
  - All-ones exponent treated as a finite number. Overflow saturates to max finite (0x7BFF/0xFBFF for FP16).
  - invalid always 0.

Test Plan:
- FP16: a=0x3C00, b=0x4000, op=0 -> result 0x4200 at cycle N+3, flags 0. Back-to-back beats every cycle give results every cycle.
- a=0x3C00, b=0x3C00, op=1 -> 0x0000 (+0). a=0x6800, b=0x3C00, op=0 -> 0x6800 (tie to even), inexact=1.
- a=b=0x7BFF -> with macro: 0x7C00, overflow=1, inexact=1. Without macro: 0x7BFF, overflow=1.
- Accumulate: acc_mode=1, a=0x3C00, 0x4000, 0x4200, 0x3800 (last) -> single output 0x4680. in_ready low during each WAIT. No out_valid before the last beat.
- Hold out_ready=0 for 5 cycles with 3 beats in flight -> result/flags stable, in_ready=0, no loss or duplication after release.
- Drive reset=0 for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, no stale results appear, accumulator restarts at +0.
